// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async 256K x 16 SRAM between host and engine.
// Optional SRAM_ARB_LOCK_EN lets the engine hold the grant across accesses.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [17:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  input  logic        proc_req,
  input  logic        proc_we,
  input  logic [17:0] proc_addr,
  input  logic [15:0] proc_wdata,
  input  logic        proc_lock,
  output logic        proc_ack,
  output logic [15:0] proc_rdata,
  output logic        SRAM_nCS,
  output logic        SRAM_nOE,
  output logic        SRAM_nWE,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] sram_dout,
  output logic        sram_doe,
  input  logic [15:0] sram_din,
  output logic        busy,
  output logic        grant_host
);

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        gh_q, gh_d;
  logic        last_host_q, last_host_d;
  logic        ncs_q, ncs_d;
  logic        noe_q, noe_d;
  logic        nwe_q, nwe_d;
  logic [17:0] sa_q, sa_d;
  logic [15:0] dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        hack_q, hack_d;
  logic        pack_q, pack_d;
  logic [15:0] hrd_q, hrd_d;
  logic [15:0] prd_q, prd_d;
  logic        busy_q, busy_d;
  logic        win_host;

`ifdef SRAM_ARB_LOCK_EN
  logic        lock_q, lock_d;
`else
  logic        unused_lock;
  assign unused_lock = proc_lock;
`endif

  // Pick the grantee: the requester that did not win last time
  always_comb begin
    win_host = host_req && (!proc_req || !last_host_q);
`ifdef SRAM_ARB_LOCK_EN
    if (lock_q && proc_req) win_host = 1'b0;
`endif
  end

  // Next state; pin values follow the current state one cycle later
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gh_d        = gh_q;
    last_host_d = last_host_q;
    ncs_d       = 1'b1;
    noe_d       = 1'b1;
    nwe_d       = 1'b1;
    sa_d        = sa_q;
    dout_d      = dout_q;
    doe_d       = 1'b0;
    hack_d      = 1'b0;
    pack_d      = 1'b0;
    hrd_d       = hrd_q;
    prd_d       = prd_q;
`ifdef SRAM_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef SRAM_ARB_LOCK_EN
        lock_d = 1'b0;
`endif
        if (host_req || proc_req) begin
          gh_d    = win_host;
          we_d    = win_host ? host_we : proc_we;
          addr_d  = win_host ? host_addr : proc_addr;
          wdata_d = win_host ? host_wdata : proc_wdata;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        ncs_d   = 1'b0;
        sa_d    = addr_q;
        cnt_d   = 4'(WAIT_CYCLES - 1);
        state_d = S_ACCESS;
        if (we_q) begin
          doe_d  = 1'b1;
          dout_d = wdata_q;
        end else begin
          noe_d = 1'b0;
        end
      end
      S_ACCESS: begin
        ncs_d = 1'b0;
        doe_d = we_q;
        nwe_d = !we_q;
        noe_d = we_q;
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (gh_q) hrd_d = sram_din;
            else      prd_d = sram_din;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        ncs_d       = 1'b0;
        doe_d       = we_q;
        hack_d      = gh_q;
        pack_d      = !gh_q;
        last_host_d = gh_q;
`ifdef SRAM_ARB_LOCK_EN
        lock_d      = !gh_q && proc_lock;
`endif
        state_d     = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gh_q        <= 1'b0;
      last_host_q <= 1'b0;
      ncs_q       <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      sa_q        <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      hack_q      <= 1'b0;
      pack_q      <= 1'b0;
      hrd_q       <= '0;
      prd_q       <= '0;
      busy_q      <= 1'b0;
`ifdef SRAM_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gh_q        <= gh_d;
      last_host_q <= last_host_d;
      ncs_q       <= ncs_d;
      noe_q       <= noe_d;
      nwe_q       <= nwe_d;
      sa_q        <= sa_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      hack_q      <= hack_d;
      pack_q      <= pack_d;
      hrd_q       <= hrd_d;
      prd_q       <= prd_d;
      busy_q      <= busy_d;
`ifdef SRAM_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign SRAM_nCS   = ncs_q;
  assign SRAM_nOE   = noe_q;
  assign SRAM_nWE   = nwe_q;
  assign SRAM_ADDR  = sa_q;
  assign sram_dout  = dout_q;
  assign sram_doe   = doe_q;
  assign host_ack   = hack_q;
  assign proc_ack   = pack_q;
  assign host_rdata = hrd_q;
  assign proc_rdata = prd_q;
  assign busy       = busy_q;
  assign grant_host = gh_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 256K x 16 async SRAM between two requesters: the host bus interface and the processing engine.
- Per access: arbitrates with round-robin, registers the selected request, sequences SRAM_nCS/nOE/nWE/ADDR/data-enable with programmable access width, returns read data plus a one-cycle ack.
- Sits between the host interface / processing core and the SRAM pins; the top level builds the tristate from sram_dout/sram_doe.

Parameters:
- WAIT_CYCLES, 2, number of ACCESS cycles with the strobe (nOE or nWE) low; legal range 1..15.

Ports:
- clk  in  1  system clock (50 MHz)
- nRESET  in  1  asynchronous active-low reset
- host_req  in  1  host access request, level
- host_we  in  1  1 = write, 0 = read
- host_addr  in  18  host word address
- host_wdata  in  16  host write data
- host_ack  out  1  one-cycle completion pulse to host
- host_rdata  out  16  last host read data
- proc_req  in  1  engine access request, level
- proc_we  in  1  1 = write, 0 = read
- proc_addr  in  18  engine word address
- proc_wdata  in  16  engine write data
- proc_lock  in  1  engine keeps the grant (used only with the optional feature)
- proc_ack  out  1  one-cycle completion pulse to engine
- proc_rdata  out  16  last engine read data
- SRAM_nCS  out  1  SRAM chip select, active low
- SRAM_nOE  out  1  SRAM output enable, active low
- SRAM_nWE  out  1  SRAM write enable, active low
- SRAM_ADDR  out  18  SRAM address
- sram_dout  out  16  data driven toward SRAM
- sram_doe  out  1  1 = drive sram_dout onto the pins
- sram_din  in  16  data read from the SRAM pins
- busy  out  1  high in any state other than IDLE
- grant_host  out  1  1 = current or last grant belongs to host

Behaviour:
- All outputs are registered.
- Reset values: SRAM_nCS=1, SRAM_nOE=1, SRAM_nWE=1, SRAM_ADDR=0, sram_dout=0, sram_doe=0, acks=0, rdata=0, busy=0, grant_host=0, state=IDLE, last_grant=proc.
- FSM states: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
- IDLE:
  - SRAM pins are idle (all strobes 1, doe=0).
  - If any req is high, pick the grantee, latch its we/addr/wdata, set grant_host, and go to SETUP.
  - Round-robin: when both requesters are high, the one not in last_grant wins. After reset the host wins first. A single requester wins immediately.
- SETUP (1 cycle):
  - nCS=0 and ADDR valid.
  - Write: doe=1 with data valid, nWE=1.
  - Read: nOE=0.
  - Load the wait counter with WAIT_CYCLES-1.
- ACCESS:
  - Write: nWE=0. Read: nOE=0.
  - Counter decrements each cycle; leave the state when the counter is 0.
  - On the last ACCESS cycle of a read, capture sram_din into the grantee's rdata.
- DONE (1 cycle):
  - nWE=1 and nOE=1; nCS=0, ADDR and doe held for write data hold time.
  - Grantee ack=1; update last_grant.
  - Next state is IDLE, where nCS returns to 1.
- Latency: IDLE sampling edge to ack = WAIT_CYCLES+2 cycles. Minimum period per access = WAIT_CYCLES+3 cycles (IDLE is always visited).
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees ack.
  - A req still high in the IDLE cycle after ack is a new access.
  - Inputs of the non-granted requester are ignored until IDLE.
- rdata is stable from the ack cycle until that requester's next read completes. Writes leave rdata unchanged.
- req dropping mid-access does not abort the access; ack is still issued.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronously). The in-flight access is lost, no ack.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- Defined: if proc_lock=1 at DONE of a proc grant, and proc_req=1 in the following IDLE, proc is granted again regardless of a pending host_req. The host waits until proc_lock=0 or proc_req=0.
- Undefined: proc_lock is ignored and pure round-robin applies.

Test Plan:
- Host write, addr 0x00123, data 0xBEEF, WAIT_CYCLES=2 -> nCS low 4 cycles; nWE low exactly 2 cycles; doe high SETUP..DONE; host_ack at cycle 4 after request sampling.
- Host read of 0x00123 with sram_din=0xBEEF during ACCESS -> host_rdata=0xBEEF in the ack cycle; nOE low 3 cycles; doe=0 throughout.
- host_req and proc_req rise in the same cycle after reset -> host is served first, then proc; grant_host=1 then 0; one ack each, never both in the same cycle.
- Both requesters held high for 4 accesses -> grants alternate H,P,H,P; period 5 cycles each.
- nRESET pulsed during ACCESS of a proc write -> nWE/nCS=1 and doe=0 immediately; no proc_ack; the next request completes normally.
- With SRAM_ARB_LOCK_EN, proc_lock=1, and 3 proc requests while host_req is high -> 3 consecutive proc grants, then host. Without the macro -> P,H,P,H.
